// File: rtl/bldc_pkg.sv
// Shared definitions for the six-step BLDC commutator.
// Holds the commutation state encodings, phase indices, last-on tags,
// and the drive table that maps a state to its PWM'd and low-on phases.
package bldc_pkg;

    // Commutation states. Codes 6 and 7 are never entered.
    localparam logic [2:0] ST_0 = 3'd0;
    localparam logic [2:0] ST_1 = 3'd1;
    localparam logic [2:0] ST_2 = 3'd2;
    localparam logic [2:0] ST_3 = 3'd3;
    localparam logic [2:0] ST_4 = 3'd4;
    localparam logic [2:0] ST_5 = 3'd5;

    // Phase indices. PH_NONE selects no phase.
    localparam logic [1:0] PH_R    = 2'd0;
    localparam logic [1:0] PH_S    = 2'd1;
    localparam logic [1:0] PH_T    = 2'd2;
    localparam logic [1:0] PH_NONE = 2'd3;

    // Which device of a phase was most recently switched on.
    localparam logic [1:0] LAST_NONE = 2'd0;
    localparam logic [1:0] LAST_HI   = 2'd1;
    localparam logic [1:0] LAST_LO   = 2'd2;

    typedef struct packed {
        logic [1:0] hi_phase;   // phase whose high side is PWM'd
        logic [1:0] lo_phase;   // phase whose low side is held on
    } drive_t;

    // Six-step drive table. The phase that is neither hi nor lo floats.
    function automatic drive_t drive_table(input logic [2:0] st);
        drive_t d;
        d.hi_phase = PH_NONE;
        d.lo_phase = PH_NONE;
        case (st)
            ST_0: begin d.hi_phase = PH_R; d.lo_phase = PH_S; end
            ST_1: begin d.hi_phase = PH_R; d.lo_phase = PH_T; end
            ST_2: begin d.hi_phase = PH_S; d.lo_phase = PH_T; end
            ST_3: begin d.hi_phase = PH_S; d.lo_phase = PH_R; end
            ST_4: begin d.hi_phase = PH_T; d.lo_phase = PH_R; end
            ST_5: begin d.hi_phase = PH_T; d.lo_phase = PH_S; end
            default: begin d.hi_phase = PH_NONE; d.lo_phase = PH_NONE; end
        endcase
        return d;
    endfunction

    // Modulo-6 step. Unreachable codes fall back into the legal ring.
    function automatic logic [2:0] next_state(input logic [2:0] st, input logic fwd);
        logic [2:0] n;
        if (fwd) begin
            n = (st >= ST_5) ? ST_0 : st + 3'd1;
        end else begin
            n = ((st == ST_0) || (st > ST_5)) ? ST_5 : st - 3'd1;
        end
        return n;
    endfunction

endpackage

// File: rtl/bldc_deadtime_phase.sv
// Purpose: one half-bridge phase gate driver with shoot-through protection.
// Latency: 1 clock from request to gate; opposite-device turn-on held until
//          the phase has been fully off for DEAD_CYCLES clocks.
// Backpressure: none; requests are levels, evaluated every clock.
// Ports: clk_i/rst_i; h_req_i, l_req_i (device requests, active-high);
//        hin_o (high-side enable, active-high); lin_n_o (low-side, active-low).
module bldc_deadtime_phase
    import bldc_pkg::*;
#(
    parameter int DEAD_CYCLES = 16,
    parameter int DEAD_W      = 5
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic h_req_i,
    input  logic l_req_i,
    output logic hin_o,
    output logic lin_n_o
);

    localparam logic [DEAD_W-1:0] DEAD_MAX = DEAD_W'(DEAD_CYCLES);

    logic              hin_q,     hin_d;
    logic              lin_q,     lin_d;      // low side, active-high internally
    logic [DEAD_W-1:0] off_cnt_q, off_cnt_d;
    logic [1:0]        last_q,    last_d;
    logic              dead_done;
    logic              legal_h,   legal_l;

    always_comb begin
        // off_cnt saturates exactly at DEAD_MAX, so equality means the hold
        // has elapsed (and is always true when DEAD_CYCLES is 0).
        dead_done = (off_cnt_q == DEAD_MAX);

        // Conflicting requests turn both devices off.
        legal_h = h_req_i & ~l_req_i;
        legal_l = l_req_i & ~h_req_i;

        // Re-enabling the device that was last on skips the dead hold, so
        // high-side chopping loses no duty.
        hin_d = legal_h & ((last_q == LAST_HI) | dead_done);
        lin_d = legal_l & ((last_q == LAST_LO) | dead_done);

        if (hin_q | lin_q) begin
            off_cnt_d = '0;
        end else if (dead_done) begin
            off_cnt_d = off_cnt_q;
        end else begin
            off_cnt_d = off_cnt_q + DEAD_W'(1);
        end

        last_d = last_q;
        if (hin_d & ~hin_q) begin
            last_d = LAST_HI;
        end else if (lin_d & ~lin_q) begin
            last_d = LAST_LO;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hin_q     <= 1'b0;
            lin_q     <= 1'b0;
            off_cnt_q <= DEAD_MAX;
            last_q    <= LAST_NONE;
        end else begin
            hin_q     <= hin_d;
            lin_q     <= lin_d;
            off_cnt_q <= off_cnt_d;
            last_q    <= last_d;
        end
    end

    assign hin_o   = hin_q;
    assign lin_n_o = ~lin_q;

endmodule

// File: rtl/bldc_commutator.sv
// Purpose: six-step BLDC commutation, PWM generation and gated bridge drive.
// Latency: step_i -> rotateState 1 clock; request -> gate 1 clock (+dead hold).
// Backpressure: none; step_i pulses are always accepted, duty_i sampled at wrap.
// Ports: clk_i/rst_i; enable_i, step_i, dir_i, duty_i (controls);
//        rotateState, duty, HIN_R/S/T, _LIN_R/S/T, pwm_wrap_o (probed outputs).
module bldc_commutator
    import bldc_pkg::*;
#(
    parameter int PWM_BITS    = 8,
    parameter int DEAD_CYCLES = 16,
    parameter int DEAD_W      = 5
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                enable_i,
    input  logic                step_i,
    input  logic                dir_i,
    input  logic [PWM_BITS-1:0] duty_i,
    output logic [2:0]          rotateState,
    output logic                duty,
    output logic                HIN_R,
    output logic                HIN_S,
    output logic                HIN_T,
    output logic                _LIN_R,
    output logic                _LIN_S,
    output logic                _LIN_T,
    output logic                pwm_wrap_o
);

    // Counter runs 0 .. 2^PWM_BITS-2 so a full-scale duty word (all ones)
    // is never reached by cnt and yields a constant-high waveform.
    localparam logic [PWM_BITS-1:0] CNT_LAST = {{(PWM_BITS-1){1'b1}}, 1'b0};

    logic [PWM_BITS-1:0] cnt_q,      cnt_d;
    logic [PWM_BITS-1:0] duty_lat_q, duty_lat_d;
    logic                duty_q,     duty_d;
    logic [2:0]          state_q,    state_d;
    logic                wrap;
    drive_t              drive;
    logic [2:0]          h_req;
    logic [2:0]          l_req;
    logic [2:0]          hin;
    logic [2:0]          lin_n;

    assign wrap = (cnt_q == CNT_LAST);

    always_comb begin
        cnt_d      = wrap ? '0 : cnt_q + PWM_BITS'(1);
        // duty_i is only taken at the period boundary so a mid-period change
        // can never produce a runt pulse.
        duty_lat_d = wrap ? duty_i : duty_lat_q;
        duty_d     = (cnt_q < duty_lat_q);
        // Position tracking continues while the bridge is disabled.
        state_d    = step_i ? next_state(state_q, dir_i) : state_q;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q      <= '0;
            duty_lat_q <= '0;
            duty_q     <= 1'b0;
            state_q    <= ST_0;
        end else begin
            cnt_q      <= cnt_d;
            duty_lat_q <= duty_lat_d;
            duty_q     <= duty_d;
            state_q    <= state_d;
        end
    end

    assign drive = drive_table(state_q);

    for (genvar p = 0; p < 3; p++) begin : g_phase
        assign h_req[p] = enable_i & (drive.hi_phase == 2'(p)) & duty_q;
        assign l_req[p] = enable_i & (drive.lo_phase == 2'(p));

        bldc_deadtime_phase #(
            .DEAD_CYCLES (DEAD_CYCLES),
            .DEAD_W      (DEAD_W)
        ) u_deadtime (
            .clk_i   (clk_i),
            .rst_i   (rst_i),
            .h_req_i (h_req[p]),
            .l_req_i (l_req[p]),
            .hin_o   (hin[p]),
            .lin_n_o (lin_n[p])
        );
    end

    assign rotateState = state_q;
    assign duty        = duty_q;
    assign pwm_wrap_o  = wrap;
    assign HIN_R       = hin[PH_R];
    assign HIN_S       = hin[PH_S];
    assign HIN_T       = hin[PH_T];
    assign _LIN_R      = lin_n[PH_R];
    assign _LIN_S      = lin_n[PH_S];
    assign _LIN_T      = lin_n[PH_T];

endmodule
